// File: rtl/stopwatch_counter_if.sv
// Stopwatch counter bus: run/pause enables from the arbiter in, BCD mm:ss
// digits and event pulses out to the display side.
// Optional macro: STOPWATCH_ADJUST_EN adds the adj/sel adjust-mode signals.
interface stopwatch_counter_if;
  logic       enable_count;
  logic       enable_pause;
`ifdef STOPWATCH_ADJUST_EN
  logic       adj;
  logic       sel;
`endif
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       sec_tick;
  logic       rollover;

  // Arbiter/display side: drives the enables, observes the time value.
  modport master (
    output enable_count,
    output enable_pause,
`ifdef STOPWATCH_ADJUST_EN
    output adj,
    output sel,
`endif
    input  min_tens,
    input  min_ones,
    input  sec_tens,
    input  sec_ones,
    input  sec_tick,
    input  rollover
  );

  // Counter side.
  modport slave (
    input  enable_count,
    input  enable_pause,
`ifdef STOPWATCH_ADJUST_EN
    input  adj,
    input  sel,
`endif
    output min_tens,
    output min_ones,
    output sec_tens,
    output sec_ones,
    output sec_tick,
    output rollover
  );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping stage: a prescaler derives a 1 Hz tick from clk while
// running, and a cascaded BCD mm:ss counter advances on each tick.
// Optional macro: STOPWATCH_ADJUST_EN enables the adjust mode (adj/sel), where
// a free-running divider steps the selected field without carry.
module stopwatch_counter #(
  parameter int CLK_HZ = 100_000_000,
  parameter int ADJ_HZ = 2
) (
  input logic                  clk,
  input logic                  reset,
  stopwatch_counter_if.slave   bus
);

  localparam int              PS_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_TC = PS_W'(CLK_HZ - 1);

  // Next value of a BCD digit; anything at or above max wraps to zero so the
  // digit can never leave its legal range.
  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] max);
    if (d >= max) begin
      return 4'd0;
    end else begin
      return d + 4'd1;
    end
  endfunction

  logic [PS_W-1:0] ps_r;
  logic [3:0]      min_tens_r, min_ones_r, sec_tens_r, sec_ones_r;
  logic [3:0]      min_tens_s, min_ones_s, sec_tens_s, sec_ones_s;
  logic            run_s, count_run_s, tick_s, wrap_s;
  logic            so_c_s, st_c_s, mo_c_s;

  // Both enables high is an illegal arbiter state and is treated as pause.
  assign run_s = bus.enable_count & ~bus.enable_pause;

`ifdef STOPWATCH_ADJUST_EN
  localparam int               DIV_N  = CLK_HZ / ADJ_HZ;
  localparam int               DIV_W  = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV_N - 1);

  logic [DIV_W-1:0] adj_div_r;
  logic             adj_pulse_s;

  assign count_run_s = run_s & ~bus.adj;
  assign adj_pulse_s = bus.adj & (adj_div_r == DIV_TC);

  // Adjust divider: free-runs while adj is high, cleared whenever adj is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      adj_div_r <= '0;
    end else if (!bus.adj) begin
      adj_div_r <= '0;
    end else if (adj_div_r == DIV_TC) begin
      adj_div_r <= '0;
    end else begin
      adj_div_r <= adj_div_r + DIV_W'(1);
    end
  end
`else
  assign count_run_s = run_s;
`endif

  // Carry chain from the current digits, qualified by the tick at the top.
  assign so_c_s = (sec_ones_r >= 4'd9);
  assign st_c_s = so_c_s & (sec_tens_r >= 4'd5);
  assign mo_c_s = st_c_s & (min_ones_r >= 4'd9);

  assign tick_s = count_run_s & (ps_r == PS_TC);
  assign wrap_s = tick_s & mo_c_s & (min_tens_r >= 4'd5);

  // Prescaler: counts only while running, so a paused partial second survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_r <= '0;
    end else if (!count_run_s) begin
      ps_r <= ps_r;
    end else if (ps_r == PS_TC) begin
      ps_r <= '0;
    end else begin
      ps_r <= ps_r + PS_W'(1);
    end
  end

  // Next-digit logic: full cascade on a tick, per-field no-carry step in adjust.
  always_comb begin
    sec_ones_s = sec_ones_r;
    sec_tens_s = sec_tens_r;
    min_ones_s = min_ones_r;
    min_tens_s = min_tens_r;
    if (tick_s) begin
      sec_ones_s = bcd_next(sec_ones_r, 4'd9);
      if (so_c_s) sec_tens_s = bcd_next(sec_tens_r, 4'd5); else sec_tens_s = sec_tens_r;
      if (st_c_s) min_ones_s = bcd_next(min_ones_r, 4'd9); else min_ones_s = min_ones_r;
      if (mo_c_s) min_tens_s = bcd_next(min_tens_r, 4'd5); else min_tens_s = min_tens_r;
`ifdef STOPWATCH_ADJUST_EN
    end else if (adj_pulse_s) begin
      if (!bus.sel) begin
        sec_ones_s = bcd_next(sec_ones_r, 4'd9);
        if (so_c_s) sec_tens_s = bcd_next(sec_tens_r, 4'd5); else sec_tens_s = sec_tens_r;
      end else begin
        min_ones_s = bcd_next(min_ones_r, 4'd9);
        if (min_ones_r >= 4'd9) min_tens_s = bcd_next(min_tens_r, 4'd5); else min_tens_s = min_tens_r;
      end
`endif
    end else begin
      sec_ones_s = sec_ones_r;
    end
  end

  // Digit registers: all four update on one edge so no ripple is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_ones_r <= 4'd0;
      sec_tens_r <= 4'd0;
      min_ones_r <= 4'd0;
      min_tens_r <= 4'd0;
    end else begin
      sec_ones_r <= sec_ones_s;
      sec_tens_r <= sec_tens_s;
      min_ones_r <= min_ones_s;
      min_tens_r <= min_tens_s;
    end
  end

  assign bus.sec_ones = sec_ones_r;
  assign bus.sec_tens = sec_tens_r;
  assign bus.min_ones = min_ones_r;
  assign bus.min_tens = min_tens_r;
  assign bus.sec_tick = tick_s;
  assign bus.rollover = wrap_s;

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping stage of the stopwatch, directly downstream of the run/pause arbiter. Consumes `enable_count`/`enable_pause` and advances a BCD mm:ss value once per second of counted time, holding it while paused. Its four BCD digits feed the seven-segment display driver. An internal prescaler derives the 1 Hz count tick from the system clock.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency; prescaler terminal count is `CLK_HZ-1`.
- `ADJ_HZ`, default 2: adjust-mode increment rate (only with the adjust macro); divider terminal count is `CLK_HZ/ADJ_HZ-1`.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `enable_count`  in  1  arbiter COUNTING indication; prescaler and digits advance only while high.
- `enable_pause`  in  1  arbiter PAUSED indication; forces hold.
- `adj`  in  1  adjust mode select (present only with `STOPWATCH_ADJUST_EN`).
- `sel`  in  1  adjust field: 0 = seconds, 1 = minutes (present only with `STOPWATCH_ADJUST_EN`).
- `min_tens`  out  4  BCD 0–5.
- `min_ones`  out  4  BCD 0–9.
- `sec_tens`  out  4  BCD 0–5.
- `sec_ones`  out  4  BCD 0–9.
- `sec_tick`  out  1  one-cycle pulse on the cycle the count advances.
- `rollover`  out  1  one-cycle pulse coincident with the 59:59 → 00:00 wrap.

## Operation
- Run condition: `run = enable_count & ~enable_pause`. If both inputs are high (illegal arbiter output), treat it as pause.
- Prescaler: `ceil(log2(CLK_HZ))`-bit counter.
  - When `run` is high: increments and wraps from `CLK_HZ-1` to 0.
  - When `run` is low: holds its value, so the partial second is preserved across a pause.
- `sec_tick` = `run` & (prescaler == `CLK_HZ-1`).
- On `sec_tick`, the digits increment as a cascaded BCD chain:
  - `sec_ones` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries into `min_ones`.
  - `min_ones` 9→0 carries into `min_tens`.
  - `min_tens` 5→0 at 59:59 wraps to 00:00 and raises `rollover` on the same cycle as `sec_tick`.
- Digits never take values outside their BCD ranges. No ripple-carry glitches are visible, because all four digits update on the same edge.
- Arbiter DEFAULT state (both enables low): the counter holds. The digits keep their current value; only `reset` clears them.
- Reset priority: `reset` overrides everything, including an in-flight tick or wrap.

## Timing
- Reset: on the first rising edge with `reset`=1, all digits = 0, prescaler = 0, and `sec_tick`, `rollover`, and the adjust divider = 0.
- `sec_tick` and `rollover` are combinational from registered state and `run`. The digits reflect the new value one cycle after `sec_tick`.
- Start latency:
  - From the first cycle `run`=1 after reset, the first `sec_tick` occurs on the `CLK_HZ`-th run cycle.
  - Digits read 00:01 on the following edge.
- Pause/resume: if `run` falls on a cycle where the prescaler = k, resuming produces `sec_tick` after `CLK_HZ-k` further run cycles.
- A `run` deassertion on the same cycle as the terminal count suppresses that tick.
- Time to wrap: 3600 ticks from 00:00.

## Configuration
- `STOPWATCH_ADJUST_EN` defined:
  - `adj`/`sel` ports exist.
  - While `adj`=1:
    - The prescaler holds and `sec_tick`/`rollover` stay 0.
    - A free-running adjust divider pulses every `CLK_HZ/ADJ_HZ` cycles.
    - Each pulse increments the selected field without carry: seconds 59→00, minutes 59→00.
  - The adjust divider clears whenever `adj`=0.
  - `reset` still has priority.
- `STOPWATCH_ADJUST_EN` undefined:
  - Ports `adj`/`sel` are absent.
  - No adjust divider is synthesized.
  - Behaviour is exactly the run/hold counter above.

## Test plan
(Bench runs with `CLK_HZ`=10, `ADJ_HZ`=2.)
- Reset then `enable_count`=1 for 10 cycles → `sec_tick` on cycle 10 only; digits 00:01 next edge; all outputs 0 during reset.
- Run 4 cycles, pause 20 cycles, resume → `sec_tick` after exactly 6 further run cycles; digits frozen during the pause.
- Preload by running 3599 ticks, then 1 more tick → `rollover`=`sec_tick`=1 same cycle; digits 59:59 → 00:00; intermediate carries 09→10 and 59→1:00 checked.
- `enable_count`=`enable_pause`=1 for 30 cycles → no tick, digits and prescaler unchanged.
- `reset` asserted on the terminal-count cycle at 00:09 → digits 00:00, no `sec_tick` effect.
- Adjust build, `adj`=1, `sel`=0 from 00:58 for 15 cycles → 3 increments: 00:59, 00:00, 00:01; minutes untouched; `rollover` stays 0.
